irq_request_latch: RTL and testbench

Interrupt front end that sits directly upstream of the 8-to-3 priority encoder. It synchronises eight raw request lines and captures edge- or level-type requests into a pending register. It presents a masked, frozen pending vector to the encoder and runs a valid/ack handshake with the service logic. The service logic returns the encoder's 3-bit result as ack_id, and the block clears that pending bit.

---
 rtl/irq_request_latch.sv | 59 +++++
 tb/tb_irq_request_latch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_request_latch.sv
// irq_request_latch: synchronises eight request lines, latches edge/level requests,
// and hands a frozen masked snapshot to the priority encoder with a valid/ack handshake.
module irq_request_latch #(
    parameter int N           = 8,
    parameter int ID_W        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    irq_in,
    input  logic [N-1:0]    edge_mode,
    input  logic [N-1:0]    mask,
    input  logic            ack,
    input  logic [ID_W-1:0] ack_id,
    input  logic            ovf_clr,
    output logic [N-1:0]    pend_o,
    output logic            irq_valid,
    output logic [N-1:0]    ovf_o,
    output logic            ack_err
);
    typedef enum logic [1:0] {IDLE, SERVICE, GAP} state_t;
    state_t state, state_n;
    logic [N-1:0] sync [SYNC_STAGES];
    logic [N-1:0] s_prev, pending, snap, rise, clr;
    logic good_ack;
    assign rise     = sync[SYNC_STAGES-1] & ~s_prev;
    assign good_ack = state == SERVICE && ack && snap[ack_id];
    // only edge-mode lines are cleared by an ack; level lines follow their source
    assign clr      = good_ack ? edge_mode & (N'(1) << ack_id) : '0;
    assign irq_valid = state == SERVICE;
    assign pend_o    = irq_valid ? snap : '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
            s_prev  <= '0;
            pending <= '0;
            snap    <= '0;
            ovf_o   <= '0;
            ack_err <= 1'b0;
            state   <= IDLE;
        end else begin
            sync[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            s_prev  <= sync[SYNC_STAGES-1];
            pending <= (edge_mode & (rise | (pending & ~clr))) | (~edge_mode & sync[SYNC_STAGES-1]);
            ovf_o   <= (ovf_clr ? '0 : ovf_o) | (edge_mode & rise & pending & ~clr);
            ack_err <= ack && !good_ack;
            state   <= state_n;
            // snapshot tracks while idle and freezes once service begins
            if (state == IDLE) snap <= pending & mask;
        end
    end
    always_comb begin
        state_n = state;
        if (state == IDLE && |(pending & mask)) state_n = SERVICE;
        if (good_ack) state_n = GAP;
        if (state == GAP) state_n = IDLE;
    end
endmodule

// File: tb/tb_irq_request_latch.sv
// tb_irq_request_latch: directed scenarios plus randomized traffic, checked against
// a behavioural model of the request latch.
module tb_irq_request_latch;
    logic       clk = 1'b0;
    logic       rst_n, ack, ovf_clr;
    logic [7:0] irq_in, edge_mode, mask;
    logic [2:0] ack_id;
    logic [7:0] pend_o, ovf_o;
    logic       irq_valid, ack_err;
    logic [17:0] obs;

    irq_request_latch dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .edge_mode(edge_mode), .mask(mask),
        .ack(ack), .ack_id(ack_id), .ovf_clr(ovf_clr), .pend_o(pend_o),
        .irq_valid(irq_valid), .ovf_o(ovf_o), .ack_err(ack_err)
    );

    always #5 clk = ~clk;
    assign obs = {pend_o, irq_valid, ovf_o, ack_err};

    int vectors = 0, miscompares = 0;

    // model: lines seen through a two-clock delay, pending set, frozen snapshot, quiet countdown
    logic [7:0] hist [3] = '{default: 8'h00};
    logic [7:0] m_pend = 0, m_snap = 0, m_ovf = 0;
    bit         m_serving = 0, m_err = 0;
    int         m_quiet = 0;

    function automatic logic [17:0] exp_out();
        return {m_serving ? m_snap : 8'h00, m_serving, m_ovf, m_err};
    endfunction

    function automatic logic [2:0] low_id(logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic tick();
        logic [7:0] rise, np, no;
        bit hit, cl;
        @(posedge clk);
        if (!rst_n) begin
            hist = '{default: 8'h00};
            m_pend = 0; m_snap = 0; m_ovf = 0; m_serving = 0; m_err = 0; m_quiet = 0;
        end else begin
            rise = hist[1] & ~hist[2];
            hit  = m_serving && ack && m_snap[ack_id];
            np   = m_pend;
            no   = ovf_clr ? 8'h00 : m_ovf;
            for (int i = 0; i < 8; i++) begin
                if (edge_mode[i]) begin
                    cl = hit && (int'(ack_id) == i);
                    if (rise[i] && m_pend[i] && !cl) no[i] = 1'b1;
                    np[i] = rise[i] || (m_pend[i] && !cl);
                end else begin
                    np[i] = hist[1][i];
                end
            end
            m_err = ack && !hit;
            if (m_serving) begin
                if (hit) begin m_serving = 0; m_quiet = 1; end
            end else if (m_quiet > 0) begin
                m_quiet--;
            end else if ((m_pend & mask) != 0) begin
                m_serving = 1;
                m_snap = m_pend & mask;
            end
            m_pend = np;
            m_ovf  = no;
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq_in;
        end
        #1;
    endtask

    task automatic drain();
        irq_in = 0; ovf_clr = 0;
        for (int c = 0; c < 40; c++) begin
            ack = m_serving && m_quiet == 0;
            ack_id = low_id(m_snap);
            tick();
            vectors++;
            if (obs !== exp_out()) begin
                miscompares++;
                $display("FAIL drain c%0d: got %h expected %h", c, obs, exp_out());
            end
        end
        ack = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; irq_in = 0; edge_mode = 8'hFF; mask = 8'hFF; ack = 0; ack_id = 0; ovf_clr = 0;
        for (int c = 0; c < 23; c++) begin
            rst_n = c >= 3;
            tick();
            vectors++;
            if (obs !== 18'h0) begin
                miscompares++;
                $display("FAIL reset_idle c%0d: got %h expected %h", c, obs, 18'h0);
            end
        end
    endtask

    task automatic test_single_edge();
        for (int c = 0; c < 10; c++) begin
            irq_in = c == 0 ? 8'h20 : 8'h00;
            ack = c == 4; ack_id = 3'd5;
            tick();
            vectors++;
            if (obs !== exp_out()) begin
                miscompares++;
                $display("FAIL single_edge c%0d: got %h expected %h", c, obs, exp_out());
            end
            if (c == 2 || c == 3 || c == 4) begin
                vectors++;
                if ({pend_o, irq_valid} !== (c == 3 ? 9'h041 : 9'h000)) begin
                    miscompares++;
                    $display("FAIL single_edge_lat c%0d: got %h expected %h", c, {pend_o, irq_valid}, (c == 3 ? 9'h041 : 9'h000));
                end
            end
        end
        ack = 0;
    endtask

    task automatic test_snapshot();
        logic [8:0] want;
        for (int c = 0; c < 11; c++) begin
            irq_in = c == 0 ? 8'h81 : c == 4 ? 8'h08 : 8'h00;
            ack = c == 8; ack_id = 3'd7;
            tick();
            vectors++;
            if (obs !== exp_out()) begin
                miscompares++;
                $display("FAIL snapshot c%0d: got %h expected %h", c, obs, exp_out());
            end
            want = c == 10 ? {8'h09, 1'b1} : (c == 8 || c == 9) ? 9'h000 : {8'h81, 1'b1};
            if (c == 3 || c == 7 || c >= 8) begin
                vectors++;
                if ({pend_o, irq_valid} !== want) begin
                    miscompares++;
                    $display("FAIL snapshot_freeze c%0d: got %h expected %h", c, {pend_o, irq_valid}, want);
                end
            end
        end
        ack = 0;
        drain();
    endtask

    task automatic test_level_mask();
        logic [8:0] want;
        edge_mode = 8'h00; irq_in = 8'h01;
        for (int c = 0; c < 10; c++) begin
            mask = c >= 6 ? 8'hFF : 8'hFE;
            ack = c == 7; ack_id = 3'd0;
            tick();
            vectors++;
            if (obs !== exp_out()) begin
                miscompares++;
                $display("FAIL level_mask c%0d: got %h expected %h", c, obs, exp_out());
            end
            want = (c == 6 || c == 9) ? 9'h003 : 9'h000;
            if (c >= 5) begin
                vectors++;
                if ({pend_o, irq_valid} !== want) begin
                    miscompares++;
                    $display("FAIL level_mask_valid c%0d: got %h expected %h", c, {pend_o, irq_valid}, want);
                end
            end
        end
        ack = 0;
        drain();
        edge_mode = 8'hFF;
        drain();
    endtask

    task automatic test_overflow();
        logic [16:0] want;
        edge_mode = 8'hFF; mask = 8'hFF;
        for (int c = 0; c < 13; c++) begin
            irq_in = (c == 0 || c == 3 || c == 7) ? 8'h04 : 8'h00;
            ack = c == 9; ack_id = 3'd2;
            ovf_clr = c == 12;
            tick();
            vectors++;
            if (obs !== exp_out()) begin
                miscompares++;
                $display("FAIL overflow c%0d: got %h expected %h", c, obs, exp_out());
            end
            want = c == 6 || c == 11 ? {8'h04, 1'b1, 8'h04} : c == 9 ? {8'h00, 1'b0, 8'h04} : c == 12 ? {8'h04, 1'b1, 8'h00} : 17'h0;
            if (c == 6 || c == 9 || c == 11 || c == 12) begin
                vectors++;
                if ({pend_o, irq_valid, ovf_o} !== want) begin
                    miscompares++;
                    $display("FAIL overflow_setwins c%0d: got %h expected %h", c, {pend_o, irq_valid, ovf_o}, want);
                end
            end
        end
        ovf_clr = 0; ack = 0;
        drain();
    endtask

    task automatic test_error_reset();
        logic [17:0] want;
        for (int c = 0; c < 12; c++) begin
            irq_in = c == 0 ? 8'h10 : 8'h00;
            rst_n = c != 6;
            ack = c == 4 || c == 7;
            ack_id = c == 4 ? 3'd3 : 3'd4;
            tick();
            vectors++;
            if (obs !== exp_out()) begin
                miscompares++;
                $display("FAIL error_reset c%0d: got %h expected %h", c, obs, exp_out());
            end
            want = c == 4 ? {8'h10, 1'b1, 8'h00, 1'b1} : c == 5 ? {8'h10, 1'b1, 8'h00, 1'b0} : c == 7 ? 18'h1 : 18'h0;
            if (c >= 4) begin
                vectors++;
                if (obs !== want) begin
                    miscompares++;
                    $display("FAIL error_reset_fixed c%0d: got %h expected %h", c, obs, want);
                end
            end
        end
        ack = 0; rst_n = 1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom % 150) != 0;
            irq_in = irq_in ^ 8'($urandom & $urandom & $urandom);
            if (c % 60 == 0) edge_mode = 8'($urandom);
            if ($urandom % 10 == 0) mask = 8'($urandom);
            ack = ($urandom % 3) == 0;
            ack_id = (m_serving && $urandom % 5 != 0) ? low_id(m_snap) : 3'($urandom);
            ovf_clr = ($urandom % 20) == 0;
            tick();
            vectors++;
            if (obs !== exp_out()) begin
                miscompares++;
                $display("FAIL random c%0d: got %h expected %h", c, obs, exp_out());
            end
        end
        rst_n = 1; ack = 0; ovf_clr = 0;
        edge_mode = 8'hFF;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_snapshot();
        test_level_mask();
        test_overflow();
        test_error_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
